// File: rtl/cell_plot_queue.sv
// cell_plot_queue
// Sits between the life-simulation engine and vga_adapter (160x120, 3-bit colour).
// Cell-change events (x, y, new state) are buffered in a small FIFO and then
// written out as one pixel per cycle on the adapter's x/y/colour/plot inputs.
// This block also owns the full-screen clear sweep. The sweep runs after reset
// and again whenever clear_req is pulsed.
//
// Optional feature, controlled by the PLOT_STATS_EN macro:
//   defined   - adds output plot_count[15:0]. It counts RUN-state plots and
//               saturates at 16'hFFFF. Reset clears it, and so does a clear_req.
//   undefined - the port and the counter are absent. Everything else behaves
//               the same.
module cell_plot_queue #(
  parameter int          DEPTH        = 16,
  parameter logic [2:0]  ALIVE_COLOUR = 3'b111,
  parameter logic [2:0]  DEAD_COLOUR  = 3'b000,
  parameter int          WIDTH        = 160,
  parameter int          HEIGHT       = 120
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic        in_alive,
  input  logic        clear_req,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot
`ifdef PLOT_STATS_EN
  ,
  output logic [15:0] plot_count
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [7:0]  X_LAST  = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_LAST  = 7'(HEIGHT - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic       alive;
    logic [6:0] y;
    logic [7:0] x;
  } entry_t;

  state_t      state;
  logic [7:0]  sweep_x;
  logic [6:0]  sweep_y;

  entry_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      head;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        head_in_range;

  // Each pointer carries an extra wrap bit. Equal pointers mean empty. Equal
  // index bits with different wrap bits mean full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // A clear_req edge takes priority over draining the queue. The head entry
  // stays queued and is drained after the sweep finishes.
  assign pop      = (state == RUN) && !clear_req && !empty;
  assign head     = mem[rd_ptr[AW-1:0]];

  // Events outside the visible grid are still stored. They are dropped when
  // they reach the head, so the adapter never sees an illegal coordinate.
  assign head_in_range = ({1'b0, head.x} < 9'(WIDTH)) && ({1'b0, head.y} < 8'(HEIGHT));

  assign busy = (state == CLEAR) || !empty || plot;

  // FIFO storage write port.
  // NOTE: the storage array is deliberately left out of the reset. The
  // pointers alone decide which entries are valid, so clearing the array would
  // only add reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_alive, in_y, in_x};
  end

  // Read/write pointers. A reset drops any queued events.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // right-hand side therefore sees the value from before the edge, in
      // whatever order the statements are written.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Clear/run controller. It produces the registered adapter outputs and
  // advances the sweep counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      sweep_x <= '0;
      sweep_y <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= DEAD_COLOUR;
      plot    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          x      <= sweep_x;
          y      <= sweep_y;
          colour <= DEAD_COLOUR;
          plot   <= 1'b1;
          if (sweep_x == X_LAST) begin
            sweep_x <= '0;
            if (sweep_y == Y_LAST) begin
              sweep_y <= '0;
              state   <= RUN;
            end else begin
              sweep_y <= sweep_y + 7'd1;
            end
          end else begin
            sweep_x <= sweep_x + 8'd1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state   <= CLEAR;
            sweep_x <= '0;
            sweep_y <= '0;
            plot    <= 1'b0;
          end else if (pop && head_in_range) begin
            x      <= head.x;
            y      <= head.y;
            colour <= head.alive ? ALIVE_COLOUR : DEAD_COLOUR;
            plot   <= 1'b1;
          end else begin
            plot <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          plot  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLOT_STATS_EN
  // Saturating count of event plots. Clear-sweep pixels are not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      plot_count <= '0;
    end else if (state == RUN) begin
      if (clear_req) begin
        plot_count <= '0;
      end else if (pop && head_in_range && (plot_count != 16'hFFFF)) begin
        plot_count <= plot_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cell_plot_queue.md
Name: cell_plot_queue

Overview:
- Downstream of the life-simulation engine and upstream of vga_adapter (160x120, 3-bit colour).
- Buffers cell-change events (x, y, new state) in a small FIFO.
- Serialises them into one-pixel-per-cycle plot writes on the adapter's x/y/colour/plot inputs.
- Owns the screen-clear sweep after reset or on request, so the engine never drives the adapter directly.

Parameters:
DEPTH, 16, FIFO entries; power of two, min 2
ALIVE_COLOUR, 3'b111, colour plotted when in_alive=1
DEAD_COLOUR, 3'b000, colour plotted when in_alive=0 and during clear sweep
WIDTH, 160, grid columns
HEIGHT, 120, grid rows

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  change event present
in_ready  out  1  queue can accept; transfer when in_valid & in_ready at rising edge
in_x  in  8  cell column
in_y  in  7  cell row
in_alive  in  1  new cell state
clear_req  in  1  single-cycle pulse: request full-screen clear
busy  out  1  clear in progress, FIFO non-empty, or plot high
x  out  8  to vga_adapter x
y  out  7  to vga_adapter y
colour  out  3  to vga_adapter colour
plot  out  1  to vga_adapter plot; one pixel per high cycle

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied.
  - x=0, y=0, colour=DEAD_COLOUR, plot=0.
  - State = CLEAR with sweep counters at (0,0).
  - in_ready=1 immediately.
- States: CLEAR, RUN.
- CLEAR:
  - Each edge registers x/y = sweep counters, colour=DEAD_COLOUR, plot=1.
  - Sweep order: x increments fastest 0..WIDTH-1, then y++.
  - First plot (0,0) appears after the first edge following reset release.
  - After plotting (WIDTH-1, HEIGHT-1) on edge k, go to RUN at edge k. Exactly WIDTH*HEIGHT = 19200 plot cycles, no gaps.
  - FIFO accepts pushes during CLEAR but is not drained.
  - clear_req during CLEAR is ignored; no restart.
- RUN:
  - If FIFO non-empty at an edge: pop head; register x=in_x, y=in_y, colour=in_alive ? ALIVE_COLOUR : DEAD_COLOUR, plot=1.
  - Otherwise plot=0; x/y/colour hold their last values.
- Latency: an event accepted on edge k is plotted (plot=1) in the cycle after edge k+1, if no older entries are queued.
- Throughput: 1 pixel/cycle; back-to-back pops allowed.
- in_ready = !full. No push-when-full bypass, even if a pop occurs on the same edge.
- Simultaneous push and pop on a non-full FIFO: both occur; count unchanged.
- Order: strict FIFO; every accepted in-range event is plotted exactly once.
- Out-of-range events (in_x >= WIDTH or in_y >= HEIGHT):
  - Accepted and stored.
  - Discarded at pop: that cycle plot=0 and x/y/colour hold.
  - A pop slot is still consumed.
- clear_req in RUN:
  - On the sampling edge: state -> CLEAR, sweep counters -> (0,0), no pop that edge.
  - Queued entries are retained and drained after the clear completes.
- Pointers: log2(DEPTH) bits plus a wrap bit; full/empty from pointer compare; wrap-around at DEPTH is seamless.
- busy is combinational: (state==CLEAR) | !empty | plot.
- Reset asserted mid-sweep or mid-drain:
  - Everything aborts and queued entries are lost.
  - The sweep restarts from (0,0) after release.

Optional Feature:
PLOT_STATS_EN
- Defined: adds output plot_count [15:0].
  - Increments on each RUN-state plot (not clear-sweep plots); saturates at 16'hFFFF.
  - Cleared by reset and by entry into CLEAR via clear_req.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Release reset, no input -> 19200 consecutive plot cycles, first (0,0) colour 0, 161st (0,1), last (159,119); then plot=0 and busy=0.
- After clear, push (10,20,alive=1) on edge k -> plot=1 with x=10, y=20, colour=3'b111 in the cycle after edge k+1, single cycle; busy low one cycle later.
- During CLEAR push 17 events -> in_ready low after the 16th is accepted; the 17th is held; after the sweep, 16 back-to-back plots in push order, then the 17th.
- In RUN push (160,5,1) then (3,4,0) -> one pop cycle with plot=0, then plot (3,4) colour 3'b000; no write at x=160.
- Queue 4 events, pulse clear_req after the first is plotted -> full 19200-cycle sweep, then remaining 3 events plotted in order.
- Assert reset_n=0 midway through the sweep with 5 events queued -> plot=0, in_ready=1 immediately; after release, sweep restarts at (0,0) and no stale events are plotted.
